// File: rtl/lo_nco_pkg.sv
// lo_nco_pkg: shared constants and types for the time-multiplexed LO NCO.
package lo_nco_pkg;

  // Default widths: output sample, phase accumulator, quarter-wave ROM address
  localparam int DSZ_DEF = 16;
  localparam int PSZ_DEF = 32;
  localparam int LSZ_DEF = 10;

  // 4-cycle frame shared with the complex mixer
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } frame_t;

  // Dither LFSR: x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form (bits 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Quadrant fold tables, bit q selects the behaviour for quadrant q.
  // MIR: read rom[~idx] instead of rom[idx]; NEG: negate the magnitude.
  localparam logic [3:0] COS_MIR = 4'b0101;
  localparam logic [3:0] COS_NEG = 4'b0110;
  localparam logic [3:0] SIN_MIR = 4'b1010;
  localparam logic [3:0] SIN_NEG = 4'b1100;

endpackage

// File: rtl/lo_nco_rom.sv
// lo_nco_rom: quarter-wave sine magnitude ROM with a registered read.
// Entry i = round((2^(DSZ-1)-1) * sin((i+0.5)*pi/2^(LSZ+1))); the half-step
// offset makes the table symmetric under ~i so mirroring needs no fix-up.
module lo_nco_rom #(
  parameter int DSZ = 16,
  parameter int LSZ = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [LSZ-1:0] addr,
  output logic [DSZ-2:0] data
);

  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = real'((2 ** (DSZ - 1)) - 1);

  logic [DSZ-2:0] tbl [2**LSZ];

  for (genvar i = 0; i < 2 ** LSZ; i++) begin : g_tbl
    localparam real ANG = (real'(i) + 0.5) * PI / real'(2 ** (LSZ + 1));
    localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign tbl[i] = (DSZ - 1)'(VAL);
  end

  // Synchronous read, one cycle of latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data <= '0;
    else        data <= tbl[addr];
  end

endmodule

// File: rtl/lo_nco.sv
// lo_nco: complex LO (lo_i = cos, lo_q = sin) on a 4-cycle frame, one sample
// per frame from a single quarter-wave ROM read twice (cos then sin).
// Optional phase dither: define LO_NCO_DITHER_EN to add a 16-bit LFSR into the
// truncated phase bits before quadrant/index extraction.
module lo_nco
  import lo_nco_pkg::*;
#(
  parameter int DSZ = DSZ_DEF,
  parameter int PSZ = PSZ_DEF,
  parameter int LSZ = LSZ_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PSZ-1:0]        freq_word,
  input  logic                  phase_rst,
  output logic signed [DSZ-1:0] lo_i,
  output logic signed [DSZ-1:0] lo_q,
  output logic                  lo_stb
);

  // Used phase field: 2 quadrant bits + LSZ index bits; TW bits below are truncated
  localparam int FW = LSZ + 2;
  localparam int TW = PSZ - FW;

  frame_t                s, s_nxt;
  logic [PSZ-1:0]        acc;
  logic [PSZ-1:0]        base;
  logic [FW-1:0]         fld;
  logic [1:0]            q;
  logic [LSZ-1:0]        idx;
  logic [LSZ-1:0]        addr;
  logic [DSZ-2:0]        rdata;
  logic                  cos_neg, sin_neg;
  logic signed [DSZ-1:0] cos_hold;
  logic                  primed;

`ifdef LO_NCO_DITHER_EN
  logic [PSZ-1:0] p;
  logic [PSZ-1:0] pd;
  logic [15:0]    lfsr;

  // Dither lands in the truncated bits only; carries ripple into idx and q
  assign pd  = p + PSZ'(TW'(lfsr));
  assign fld = pd[PSZ-1 -: FW];

  // LFSR steps once per frame, in step with the phase update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       lfsr <= LFSR_SEED;
    else if (s == S0) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end
`else
  // Without dither the truncated bits never matter, so only the field is kept
  logic [FW-1:0] p;
  assign fld = p;
`endif

  assign q    = fld[FW-1 -: 2];
  assign idx  = fld[LSZ-1:0];
  assign base = phase_rst ? '0 : acc;

  // Attach the fold sign to a ROM magnitude; max magnitude keeps negation in range
  function automatic logic signed [DSZ-1:0] apply_sign(input logic [DSZ-2:0] m,
                                                        input logic n);
    logic signed [DSZ-1:0] v;
    v = $signed({1'b0, m});
    return n ? -v : v;
  endfunction

  // Frame counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s <= S0;
    else        s <= s_nxt;
  end

  // Frame counter runs free S0->S1->S2->S3->S0
  always_comb begin
    s_nxt = S0;
    unique case (s)
      S0: s_nxt = S1;
      S1: s_nxt = S2;
      S2: s_nxt = S3;
      S3: s_nxt = S0;
    endcase
  end

  // Phase accumulator; freq_word and phase_rst only matter on the S0 edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      p   <= '0;
    end else if (s == S0) begin
`ifdef LO_NCO_DITHER_EN
      p   <= base;
`else
      p   <= base[PSZ-1 -: FW];
`endif
      acc <= base + freq_word;
    end
  end

  // ROM sequencing, sign folding and output registers across the frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr     <= '0;
      cos_neg  <= 1'b0;
      sin_neg  <= 1'b0;
      cos_hold <= '0;
      lo_i     <= '0;
      lo_q     <= '0;
      lo_stb   <= 1'b0;
      primed   <= 1'b0;
    end else begin
      unique case (s)
        S0: begin
          // First frame after reset has no finished sample yet: no strobe
          lo_i   <= cos_hold;
          lo_q   <= apply_sign(rdata, sin_neg);
          lo_stb <= primed;
          primed <= 1'b1;
        end
        S1: begin
          addr    <= COS_MIR[q] ? ~idx : idx;
          cos_neg <= COS_NEG[q];
          lo_stb  <= 1'b0;
        end
        S2: begin
          addr    <= SIN_MIR[q] ? ~idx : idx;
          sin_neg <= SIN_NEG[q];
        end
        S3: begin
          cos_hold <= apply_sign(rdata, cos_neg);
        end
      endcase
    end
  end

  lo_nco_rom #(
    .DSZ (DSZ),
    .LSZ (LSZ)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .data  (rdata)
  );

endmodule

// File: tb/tb_lo_nco.sv
// tb_lo_nco: directed, table-driven bench for lo_nco (default widths, no dither).
module tb_lo_nco;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [31:0]        freq_word = '0;
  logic               phase_rst = 1'b0;
  logic signed [15:0] lo_i, lo_q;
  logic               lo_stb;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;   // posedges since last reset release; edge n ends S0 when n%4==1

  always #5 clk = ~clk;

  lo_nco dut (
    .clk       (clk),
    .reset     (reset),
    .freq_word (freq_word),
    .phase_rst (phase_rst),
    .lo_i      (lo_i),
    .lo_q      (lo_q),
    .lo_stb    (lo_stb)
  );

  typedef struct packed {
    logic [31:0]      fw;
    logic [3:0][15:0] ei;
    logic [3:0][15:0] eq;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] fw,
                              input int i0, input int q0, input int i1, input int q1,
                              input int i2, input int q2, input int i3, input int q3);
    vec_t v;
    v.fw    = fw;
    v.ei[0] = 16'(i0); v.eq[0] = 16'(q0);
    v.ei[1] = 16'(i1); v.eq[1] = 16'(q1);
    v.ei[2] = 16'(i2); v.eq[2] = 16'(q2);
    v.ei[3] = 16'(i3); v.eq[3] = 16'(q3);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_iq(input string nm, input int ei, input int eq);
    chk({nm, ".i"}, int'(lo_i), ei);
    chk({nm, ".q"}, int'(lo_q), eq);
  endtask

  // One clock: advance past the posedge, then sample/drive on the negedge
  task automatic tick();
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  // Align so the next posedge is an S0 edge, then restart phase at 0 with fw
  task automatic restart(input logic [31:0] fw);
    while (ecnt % 4 != 0) tick();
    freq_word = fw;
    phase_rst = 1'b1;
    tick();
    phase_rst = 1'b0;
  endtask

  vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(32'h0000_0000, 32767, 25, 32767, 25, 32767, 25, 32767, 25);
    vt[1] = mk(32'h4000_0000, 32767, 25, -25, 32767, -32767, -25, 25, -32767);
    vt[2] = mk(32'hC000_0000, 32767, 25, 25, -32767, -32767, -25, -25, 32767);
    vt[3] = mk(32'h0010_0000, 32767, 25, 32767, 75, 32767, 126, 32767, 176);
    vt[4] = mk(32'h000F_FFFF, 32767, 25, 32767, 25, 32767, 75, 32767, 126);
    vt[5] = mk(32'hFFF0_0000, 32767, 25, 32767, -25, 32767, -75, 32767, -126);

    // Power-up reset: outputs clear immediately and stay clear
    #2 reset = 1'b0;
    #1;
    chk_iq("rst0", 0, 0);
    chk("rst0.stb", int'(lo_stb), 0);
    repeat (10) @(negedge clk);
    chk_iq("rst10", 0, 0);
    chk("rst10.stb", int'(lo_stb), 0);
    reset = 1'b1;
    ecnt  = 0;

    // First strobe 4 edges after the first S0 edge; DC output thereafter
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk($sformatf("pu.stb%0d", n), int'(lo_stb), int'(n >= 5 && n % 4 == 1));
      if (n < 5) chk_iq($sformatf("pu.idle%0d", n), 0, 0);
      else       chk_iq($sformatf("pu.dc%0d", n), 32767, 25);
    end

    // Table: restart at phase 0, then four consecutive samples
    for (int v = 0; v < 6; v++) begin
      restart(vt[v].fw);
      for (int k = 0; k < 4; k++) begin
        tick(); tick(); tick();
        chk($sformatf("v%0d.s%0d.stb_lo", v, k), int'(lo_stb), 0);
        tick();
        chk($sformatf("v%0d.s%0d.stb_hi", v, k), int'(lo_stb), 1);
        chk_iq($sformatf("v%0d.s%0d", v, k),
               int'($signed(vt[v].ei[k])), int'($signed(vt[v].eq[k])));
      end
    end

    // Nyquist across many accumulator wraps
    restart(32'h8000_0000);
    for (int k = 0; k < 1000; k++) begin
      repeat (4) tick();
      if (k % 2 == 0) chk_iq($sformatf("nyq%0d", k), 32767, 25);
      else            chk_iq($sformatf("nyq%0d", k), -32767, -25);
    end

    // Junk freq_word and a phase_rst pulse during S2, restored in S3: no effect
    restart(32'h4000_0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      freq_word = 32'h1234_5678;
      phase_rst = 1'b1;
      tick();
      freq_word = 32'h4000_0000;
      phase_rst = 1'b0;
      tick(); tick();
      chk_iq($sformatf("glitch%0d", k),
             int'($signed(vt[1].ei[k])), int'($signed(vt[1].eq[k])));
    end

    // freq_word changed at S2 takes effect from the next S0 edge
    restart(32'h4000_0000);
    tick();
    freq_word = 32'h8000_0000;
    tick(); tick(); tick();
    chk_iq("fchg0", 32767, 25);
    repeat (4) tick();
    chk_iq("fchg1", -25, 32767);
    repeat (4) tick();
    chk_iq("fchg2", 25, -32767);
    repeat (4) tick();
    chk_iq("fchg3", -25, 32767);

    // phase_rst held across S0 edges
    restart(32'h4000_0000);
    repeat (4) tick();
    chk_iq("hold0", 32767, 25);
    tick(); tick();
    phase_rst = 1'b1;
    tick(); tick();
    chk_iq("hold1", -25, 32767);
    repeat (4) tick();
    chk_iq("hold2", 32767, 25);
    repeat (4) tick();
    chk_iq("hold3", 32767, 25);
    phase_rst = 1'b0;
    repeat (4) tick();
    chk_iq("hold4", 32767, 25);
    repeat (4) tick();
    chk_iq("hold5", -25, 32767);

    // Reset mid-frame (S2): immediate clear, then power-up behaviour
    tick();
    reset = 1'b0;
    #1;
    chk_iq("mrst", 0, 0);
    chk("mrst.stb", int'(lo_stb), 0);
    @(negedge clk);
    @(negedge clk);
    chk_iq("mrst2", 0, 0);
    reset = 1'b1;
    ecnt  = 0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk($sformatf("mr.stb%0d", n), int'(lo_stb), int'(n >= 5 && n % 4 == 1));
      if (n < 5)       chk_iq($sformatf("mr.idle%0d", n), 0, 0);
      else if (n < 9)  chk_iq($sformatf("mr.s0_%0d", n), 32767, 25);
      else             chk_iq($sformatf("mr.s1_%0d", n), -25, 32767);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
